// File: rtl/buffer_supplier.sv
// buffer_supplier
//   Producer end of the buffer -> scratchpad handshake for one CNN PE.
//   Upstream words enter a first-word-fall-through FIFO. The head word is
//   presented on valid/dout, and one word is popped per req_buffer pulse.
//   A saturating occupancy counter tracks how many scratchpad slots are
//   filled. It drives permission.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_data     upstream word
//   in_valid    upstream word present
//   in_ready    FIFO can accept (!full)
//   valid       FIFO non-empty
//   dout        head word (combinational from storage)
//   req_buffer  one-cycle pop request from the scratchpad read controller
//   permission  scratchpad has a free slot
//   sp_release  one-cycle pulse, PE consumed one scratchpad slot
//   err         sticky protocol error
//
// Optional feature
//   BUF_ERR_CHECK_EN : when defined, err latches on underflow (req_buffer
//                      while empty) or over-release (sp_release while the
//                      occupancy is 0). When undefined, err is tied to 0.

module buffer_supplier #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int SP_SIZE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              valid,
    output logic [DATA_W-1:0] dout,
    input  logic              req_buffer,
    output logic              permission,
    input  logic              sp_release,
    output logic              err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SP_W  = $clog2(SP_SIZE + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [SP_W-1:0]   sp_used;

    logic full;
    logic push;
    logic pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign in_ready   = !full;
    assign valid      = (count != '0);
    assign push       = in_valid && !full;
    assign pop        = req_buffer && valid;
    assign dout       = mem[rd_ptr];
    assign permission = (sp_used < SP_W'(SP_SIZE));

    // Storage is not reset. dout is only meaningful while valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Occupancy saturates at both ends rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_used <= '0;
        end else begin
            case ({pop, sp_release})
                2'b10: begin
                    if (sp_used != SP_W'(SP_SIZE)) begin
                        sp_used <= sp_used + SP_W'(1);
                    end
                end
                2'b01: begin
                    if (sp_used != '0) begin
                        sp_used <= sp_used - SP_W'(1);
                    end
                end
                default: sp_used <= sp_used;
            endcase
        end
    end

`ifdef BUF_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((req_buffer && !valid) || (sp_release && sp_used == '0)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_supplier.sv
module tb_buffer_supplier;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int SP_SIZE = 4;

`ifdef BUF_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              valid;
    logic [DATA_W-1:0] dout;
    logic              req_buffer;
    logic              permission;
    logic              sp_release;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    buffer_supplier #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SP_SIZE(SP_SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .valid      (valid),
        .dout       (dout),
        .req_buffer (req_buffer),
        .permission (permission),
        .sp_release (sp_release),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus an integer occupancy.
    logic [DATA_W-1:0] m_q[$];
    int                m_sp  = 0;
    bit                m_err = 1'b0;
    bit                m_push, m_pop;
    bit                chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_sp  = 0;
            m_err = 1'b0;
        end else begin
            m_push = in_valid && (m_q.size() < DEPTH);
            m_pop  = req_buffer && (m_q.size() > 0);
            if (ERR_EN && ((req_buffer && m_q.size() == 0) || (sp_release && m_sp == 0)))
                m_err = 1'b1;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back(in_data);
            if (m_pop && !sp_release && m_sp < SP_SIZE) m_sp++;
            else if (sp_release && !m_pop && m_sp > 0) m_sp--;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", 32'(valid), 32'(m_q.size() > 0));
            chk("model_in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
            chk("model_permission", 32'(permission), 32'(m_sp < SP_SIZE));
            chk("model_err", 32'(err), 32'(m_err));
            if (m_q.size() > 0) chk("model_dout", 32'(dout), 32'(m_q[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; req_buffer = 1'b0; sp_release = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_permission", 32'(permission), 32'd1);
        chk("rst_err", 32'(err), 32'd0);

        // Push 0x11, 0x22, 0x33 and pop them back in order.
        in_valid = 1'b1; in_data = 8'h11; step();
        chk("first_push_valid", 32'(valid), 32'd1);
        chk("first_push_dout", 32'(dout), 32'h11);
        in_data = 8'h22; step();
        in_data = 8'h33; step();
        in_valid = 1'b0;
        req_buffer = 1'b1; step();
        chk("pop1_dout", 32'(dout), 32'h22);
        step();
        chk("pop2_dout", 32'(dout), 32'h33);
        step();
        req_buffer = 1'b0;
        chk("pop3_valid", 32'(valid), 32'd0);
        chk("sp_used_3", 32'(dut.sp_used), 32'd3);
        sp_release = 1'b1; repeat (3) step(); sp_release = 1'b0;
        chk("sp_used_0", 32'(dut.sp_used), 32'd0);

        // Fill to full with in_valid held; the fifth word must be dropped.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hA0 + 8'(i);
            step();
            if (i == 3) chk("full_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk("full_count", 32'(dut.count), 32'd4);
        chk("full_head", 32'(dout), 32'hA0);

        // Four pops, no releases: scratchpad fills.
        req_buffer = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(dout), 32'(8'hA0 + 8'(i)));
            step();
        end
        req_buffer = 1'b0;
        chk("sp_full_permission", 32'(permission), 32'd0);
        chk("drain_valid", 32'(valid), 32'd0);
        sp_release = 1'b1; step(); sp_release = 1'b0;
        chk("release_permission", 32'(permission), 32'd1);
        sp_release = 1'b1; step(); sp_release = 1'b0;
        chk("sp_used_2", 32'(dut.sp_used), 32'd2);

        // Simultaneous pop and release at sp_used=2.
        in_valid = 1'b1; in_data = 8'hB1; step();
        in_data = 8'hB2; step();
        in_valid = 1'b0;
        req_buffer = 1'b1; sp_release = 1'b1; step();
        req_buffer = 1'b0; sp_release = 1'b0;
        chk("pop_release_sp_used", 32'(dut.sp_used), 32'd2);
        chk("pop_release_dout", 32'(dout), 32'hB2);

        // Simultaneous push and pop at count=2.
        in_valid = 1'b1; in_data = 8'hB3; step();
        chk("count_2", 32'(dut.count), 32'd2);
        in_data = 8'hB4; req_buffer = 1'b1; step();
        in_valid = 1'b0; req_buffer = 1'b0;
        chk("push_pop_count", 32'(dut.count), 32'd2);
        chk("push_pop_dout", 32'(dout), 32'hB3);

        // Free the scratchpad, drain, then pop while empty.
        sp_release = 1'b1; repeat (3) step(); sp_release = 1'b0;
        req_buffer = 1'b1; step();
        chk("drain_b4", 32'(dout), 32'hB4);
        step(); step();
        req_buffer = 1'b0;
        chk("empty_count", 32'(dut.count), 32'd0);
        chk("empty_sp_used", 32'(dut.sp_used), 32'd2);
        chk("underflow_err", 32'(err), 32'(ERR_EN));
        in_valid = 1'b1; in_data = 8'hC1; step();
        in_valid = 1'b0;
        chk("after_empty_dout", 32'(dout), 32'hC1);
        step();
        chk("err_sticky", 32'(err), 32'(ERR_EN));
        req_buffer = 1'b1; step(); req_buffer = 1'b0;
        chk("sp_used_3b", 32'(dut.sp_used), 32'd3);

        // Reset mid-operation with 3 words stored and sp_used=3.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hD1 + 8'(i);
            step();
        end
        chk("pre_rst_count", 32'(dut.count), 32'd3);
        rst = 1'b1; req_buffer = 1'b1; sp_release = 1'b1; in_data = 8'hEE;
        step();
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_permission", 32'(permission), 32'd1);
        chk("mid_rst_err", 32'(err), 32'd0);
        rst = 1'b0; in_valid = 1'b0; req_buffer = 1'b0; sp_release = 1'b0;
        step();
        chk("post_rst_valid", 32'(valid), 32'd0);
        step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
